// File: rtl/fetch_pc_unit.sv
// Purpose: program counter and instruction-fetch stage; one outstanding IM request, one-entry decode buffer.
// Latency: IM_ACK to INSTR_VALID is one edge; peak rate is one instruction every two cycles.
// Backpressure: INSTR_READY=0 holds INSTR/INSTR_PC stable and stalls the next fetch; redirects flush the buffer.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   PC_OUT / SEQ_PC           current PC to the external +4 adder, and its sum back
//   IM_REQ/IM_ADDR/IM_ACK/IM_DATA   instruction-memory req/ack channel
//   REDIRECT/REDIRECT_PC      branch/jump target
//   INSTR/INSTR_PC/INSTR_VALID/INSTR_READY   valid/ready channel to decode
// Optional build macro FETCH_ALIGN_CHECK_EN: adds ALIGN_ERR and forces redirect targets word-aligned.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] PC_OUT,
    input  logic [31:0] SEQ_PC,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    input  logic        IM_ACK,
    input  logic [31:0] IM_DATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        ALIGN_ERR
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;
`endif

    always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
        tgt         = {REDIRECT_PC[31:2], 2'b00};
        // Every redirect is acted on in every state, so any misaligned one is flagged.
        align_err_d = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
`else
        tgt         = REDIRECT_PC;
`endif
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                if (REDIRECT) begin
                    pc_d   = tgt;
                    addr_d = tgt;
                end else begin
                    addr_d = pc_q;
                end
            end
            FETCH: begin
                if (IM_ACK && !REDIRECT) begin
                    instr_d    = IM_DATA;
                    instr_pc_d = addr_q;
                    valid_d    = 1'b1;
                    pc_d       = SEQ_PC;
                    req_d      = 1'b0;
                    state_d    = HOLD;
                end else if (IM_ACK && REDIRECT) begin
                    // Returned word is on the wrong path; reissue at the target immediately.
                    pc_d   = tgt;
                    addr_d = tgt;
                end else if (REDIRECT) begin
                    // Memory still owes us a word for addr_q; keep the request stable and wait it out.
                    pc_d    = tgt;
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (REDIRECT) begin
                    valid_d = 1'b0;
                    pc_d    = tgt;
                    addr_d  = tgt;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (INSTR_READY) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (REDIRECT) begin
                    pc_d = tgt;
                end
                if (IM_ACK) begin
                    // Stale data dropped; the newest target is what gets requested next.
                    addr_d  = REDIRECT ? tgt : pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
    assign ALIGN_ERR = align_err_q;
`endif

    assign PC_OUT      = pc_q;
    assign IM_REQ      = req_q;
    assign IM_ADDR     = addr_q;
    assign INSTR       = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign INSTR_VALID = valid_q;

endmodule
